// File: rtl/step_motor_pkg.sv
// Shared types and constants for the stepper motor controller.
//   mode_e      : command mode encoding (reserved mode behaves as half-step)
//   state_e     : controller FSM states
//   COIL_TABLE  : 8-entry winding pattern table, entry i at COIL_TABLE[i]
//   next_idx()  : phase-index advance for one step
package step_motor_pkg;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'd0,
    MODE_FULL = 2'd1,
    MODE_HALF = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  // Wave mode lives on even indices, full mode on odd ones. A step taken
  // from the "wrong" parity moves by one so the next step lands aligned.
  function automatic logic [2:0] next_idx(input logic [2:0] idx,
                                          input logic       dir,
                                          input mode_e      mode);
    logic [2:0] delta;
    delta = 3'd1;
    if (mode == MODE_WAVE && !idx[0]) delta = 3'd2;
    if (mode == MODE_FULL &&  idx[0]) delta = 3'd2;
    return dir ? idx + delta : idx - delta;
  endfunction

endpackage

// File: rtl/step_rate_gen.sv
// Step-rate generator: period down-counter producing a one-cycle tick.
//   clk_i    : rising-edge clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : restart, latches period_i (0 is treated as 1)
//   period_i : clocks between ticks
//   run_i    : count enable
//   tick_o   : high for one cycle every period clocks while running
module step_rate_gen
  import step_motor_pkg::*;
#(
  parameter int unsigned PERIOD_W = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                run_i,
  output logic                tick_o
);

  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period_i == '0) ? PERIOD_W'(1) : period_i;
  assign tick_o     = run_i && (cnt_q == PERIOD_W'(1));

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      period_d = period_eff;
      cnt_d    = period_eff;
    end else if (run_i) begin
      cnt_d = (cnt_q == PERIOD_W'(1)) ? period_q : cnt_q - PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_q <= PERIOD_W'(1);
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/step_motor_ctrl.sv
// Stepper motor move controller.
//   clk, rst (async, active-low)
//   cmd_valid/cmd_ready handshake with cmd_steps, cmd_dir, cmd_mode, cmd_period
//   abort       : stop a running move (ignored when idle)
//   coil        : winding drive pattern
//   step_pulse  : one-cycle pulse per step taken
//   busy / done : move in progress / one-cycle end-of-move pulse
//   position    : signed cumulative step count (wraps)
// Optional build macro STEP_MOTOR_IDLE_OFF_EN: de-energise coils after
// IDLE_TICKS consecutive idle clocks; re-energised on the next command.
module step_motor_ctrl
  import step_motor_pkg::*;
#(
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned PERIOD_W   = 20,
  parameter int unsigned POS_W      = 24,
  parameter int unsigned IDLE_TICKS = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    cmd_dir,
  input  logic [1:0]              cmd_mode,
  input  logic [PERIOD_W-1:0]     cmd_period,
  input  logic                    abort,
  output logic [3:0]              coil,
  output logic                    step_pulse,
  output logic                    busy,
  output logic                    done,
  output logic signed [POS_W-1:0] position
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                dir_q, dir_d;
  mode_e               mode_q, mode_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          coil_q, coil_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                step_pulse_q, step_pulse_d;
  logic                done_q, done_d;
  logic                accept;
  logic                run;
  logic                tick;
  logic [2:0]          idx_n;

`ifdef STEP_MOTOR_IDLE_OFF_EN
  localparam int unsigned IW = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_TICKS);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  assign accept     = cmd_valid && (state_q == ST_IDLE);
  assign run        = (state_q == ST_RUN);
  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = run;
  assign coil       = coil_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;
  assign position   = pos_q;

  step_rate_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_rate (
    .clk_i    (clk),
    .rst_ni   (rst),
    .start_i  (accept),
    .period_i (cmd_period),
    .run_i    (run),
    .tick_o   (tick)
  );

  always_comb begin
    state_d      = state_q;
    steps_d      = steps_q;
    dir_d        = dir_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    coil_d       = coil_q;
    pos_d        = pos_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
    idx_n        = next_idx(idx_q, dir_q, mode_q);

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          steps_d = cmd_steps;
          dir_d   = cmd_dir;
          mode_d  = mode_e'(cmd_mode);
          coil_d  = COIL_TABLE[idx_q];
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort takes priority over a step due in the same cycle.
        if (abort || steps_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          idx_d        = idx_n;
          coil_d       = COIL_TABLE[idx_n];
          pos_d        = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          step_pulse_d = 1'b1;
          steps_d      = steps_q - STEP_W'(1);
          if (steps_q == STEP_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef STEP_MOTOR_IDLE_OFF_EN
    // Counts consecutive idle clocks; saturates so the coil stays off.
    idle_cnt_d = '0;
    if (state_q == ST_IDLE && !cmd_valid) begin
      idle_cnt_d = idle_cnt_q;
      if (idle_cnt_q != IDLE_LIM) idle_cnt_d = idle_cnt_q + IW'(1);
      if (idle_cnt_q == IDLE_LIM - IW'(1)) coil_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      steps_q      <= '0;
      dir_q        <= 1'b0;
      mode_q       <= MODE_WAVE;
      idx_q        <= '0;
      coil_q       <= '0;
      pos_q        <= '0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      steps_q      <= steps_d;
      dir_q        <= dir_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      coil_q       <= coil_d;
      pos_q        <= pos_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
    end
  end

`ifdef STEP_MOTOR_IDLE_OFF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_cnt_q <= '0;
    else      idle_cnt_q <= idle_cnt_d;
  end
`endif

endmodule

// File: tb/tb_step_motor_ctrl.sv
// Self-checking bench for step_motor_ctrl: directed moves plus randomized
// moves, compared cycle by cycle against an arithmetic reference model.
// Build with STEP_MOTOR_IDLE_OFF_EN defined to exercise the idle-off feature.
module tb_step_motor_ctrl;

  localparam int unsigned STEP_W   = 6;
  localparam int unsigned PERIOD_W = 3;
  localparam int unsigned POS_W    = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [STEP_W-1:0]       cmd_steps;
  logic                    cmd_dir;
  logic [1:0]              cmd_mode;
  logic [PERIOD_W-1:0]     cmd_period;
  logic                    abort;
  logic [3:0]              coil;
  logic                    step_pulse;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] position;

  step_motor_ctrl #(
    .STEP_W     (STEP_W),
    .PERIOD_W   (PERIOD_W),
    .POS_W      (POS_W),
    .IDLE_TICKS (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_mode   (cmd_mode),
    .cmd_period (cmd_period),
    .abort      (abort),
    .coil       (coil),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [3:0] table_m [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0100, 4'b1100, 4'b1000, 4'b1001};
  int         model_idx;
  int         model_pos;
  logic [3:0] exp_coil;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] pos_bits(input int p);
    logic [31:0] v;
    v = p;
    return v[5:0];
  endfunction

  // Step size from the mode rules: wave wants even idx, full wants odd idx.
  function automatic int step_size(input int idx, input int mode);
    if (mode == 0) return (idx % 2 == 0) ? 2 : 1;
    if (mode == 1) return (idx % 2 == 1) ? 2 : 1;
    return 1;
  endfunction

  task automatic check_outputs(input string tag, input bit exp_pulse,
                               input bit exp_done, input bit exp_busy);
    check_eq({tag, ".pulse"}, step_pulse, exp_pulse);
    check_eq({tag, ".done"}, done, exp_done);
    check_eq({tag, ".busy"}, busy, exp_busy);
    check_eq({tag, ".ready"}, cmd_ready, !exp_busy);
    check_eq({tag, ".coil"}, coil, exp_coil);
    check_eq({tag, ".pos"}, position[5:0], pos_bits(model_pos));
  endtask

  // Issues one command and follows it to completion. abort_at = n asserts
  // abort for the edge on which step n would fire (0 = no abort).
  task automatic run_move(input string tag, input int s, input bit d,
                          input int m, input int p, input int abort_at,
                          input bit scramble);
    int pe, n, st;
    bit fin, exp_pulse, exp_done;
    pe = (p == 0) ? 1 : p;
    check_eq({tag, ".ready0"}, cmd_ready, 1);
    cmd_steps  = STEP_W'(s);
    cmd_dir    = d;
    cmd_mode   = 2'(m);
    cmd_period = PERIOD_W'(p);
    cmd_valid  = 1'b1;
    abort      = 1'($urandom_range(0, 1));  // must be ignored when idle
    @(posedge clk); #1;
    abort = 1'b0;
    if (!scramble) cmd_valid = 1'b0;
    exp_coil = table_m[model_idx];
    check_outputs({tag, ".acc"}, 0, 0, 1);
    n = 0;
    fin = 0;
    for (int k = 1; !fin && k <= s * pe + 1; k++) begin
      if (abort_at != 0 && k == abort_at * pe) abort = 1'b1;
      if (scramble) begin
        cmd_valid  = 1'b1;
        cmd_steps  = STEP_W'($urandom);
        cmd_dir    = 1'($urandom);
        cmd_mode   = 2'($urandom);
        cmd_period = PERIOD_W'($urandom);
      end
      @(posedge clk); #1;
      exp_pulse = 0;
      exp_done  = 0;
      if (abort || s == 0) begin
        exp_done = 1;
        fin = 1;
      end else if (k % pe == 0) begin
        st = step_size(model_idx, m);
        model_idx = d ? (model_idx + st) % 8 : (model_idx + 8 - st) % 8;
        model_pos = d ? model_pos + 1 : model_pos - 1;
        exp_coil  = table_m[model_idx];
        exp_pulse = 1;
        n++;
        if (n == s) begin
          exp_done = 1;
          fin = 1;
        end
      end
      abort = 1'b0;
      check_outputs(tag, exp_pulse, exp_done, !fin);
      if (fin) cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int s, a;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir = 1'b0;
    cmd_mode = '0;
    cmd_period = '0;
    abort = 1'b0;
    model_idx = 0;
    model_pos = 0;
    exp_coil = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Half forward 8 @ period 4: full table cycle, back to 0001 at +8
    run_move("half8", 8, 1, 2, 4, 0, 0);
    check_eq("half8.coil_end", coil, 4'b0001);
    check_eq("half8.pos_end", position[5:0], 6'd8);
    // Full reverse 3 from idx 0: 7, 5, 3
    run_move("full_rev3", 3, 0, 1, 5, 0, 0);
    check_eq("full_rev3.coil_end", coil, 4'b0110);
    check_eq("full_rev3.pos_end", position[5:0], 6'd5);
    run_move("period0", 5, 1, 0, 0, 0, 0);
    run_move("zero_steps", 0, 1, 2, 3, 0, 0);
    run_move("abort3", 10, 1, 2, 2, 3, 0);
    run_move("scramble", 6, 0, 3, 3, 0, 1);

    // Idle hold / de-energise
    repeat (15) @(posedge clk);
    #1;
    check_eq("idle15.coil", coil, exp_coil);
    @(posedge clk); #1;
`ifdef STEP_MOTOR_IDLE_OFF_EN
    exp_coil = 4'b0000;
`endif
    check_eq("idle16.coil", coil, exp_coil);
    repeat (30) @(posedge clk);
    #1;
    check_eq("idle46.coil", coil, exp_coil);
    run_move("wake", 2, 1, 1, 1, 0, 0);

    // Randomized moves
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 12);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, s + 1) : 0;
      run_move("rand", s, 1'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 7), a, 1'($urandom));
    end

    // Reset in the middle of a move discards it
    cmd_steps = STEP_W'(9);
    cmd_dir = 1'b1;
    cmd_mode = 2'd2;
    cmd_period = PERIOD_W'(1);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_idx = 0;
    model_pos = 0;
    exp_coil = 4'b0000;
    check_outputs("midrst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_move("after_rst", 4, 0, 0, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_motor_ctrl.md
STEP_MOTOR_CTRL -- requirements
Module: step_motor_ctrl

Interface
REQ-001 The module SHALL have parameter STEP_W, default 16, meaning width of the step-count field.
REQ-002 The module SHALL have parameter PERIOD_W, default 20, meaning width of the step-period field in clock cycles.
REQ-003 The module SHALL have parameter POS_W, default 24, meaning width of the signed position counter.
REQ-004 The module SHALL have parameter IDLE_TICKS, default 50_000_000, meaning the idle de-energise timeout in clocks (used only under REQ-027).
REQ-005 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The module SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-008 The module SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-009 The module SHALL have port cmd_steps, input, STEP_W bits: number of steps.
REQ-010 The module SHALL have port cmd_dir, input, 1 bit: 1 = forward, 0 = reverse.
REQ-011 The module SHALL have port cmd_mode, input, 2 bits: 0 = wave, 1 = full two-phase, 2 = half, 3 = reserved (treated as half).
REQ-012 The module SHALL have port cmd_period, input, PERIOD_W bits: clocks between steps.
REQ-013 The module SHALL have port abort, input, 1 bit: stop the running move.
REQ-014 The module SHALL have port coil, output, 4 bits: winding drive.
REQ-015 The module SHALL have port step_pulse, output, 1 bit: one-cycle pulse per step taken.
REQ-016 The module SHALL have port busy, output, 1 bit: move in progress.
REQ-017 The module SHALL have port done, output, 1 bit: one-cycle pulse at move end.
REQ-018 The module SHALL have port position, output, POS_W bits, signed: cumulative step position.

Function
REQ-019 The module SHALL implement an FSM with states IDLE and RUN; cmd_ready = (state == IDLE); busy = (state == RUN).
REQ-020 The module SHALL, on acceptance, latch steps, dir, mode and period (period 0 SHALL be treated as 1), drive coil = TABLE[idx] on the next cycle, and enter RUN; the latched values SHALL ignore input changes during RUN.
REQ-021 TABLE[0..7] SHALL be 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001, with phase index idx 3-bit, wrapping modulo 8 in both directions.
REQ-022 Each step SHALL move idx by ±1 in half mode and by ±2 in wave mode (even idx) and full mode (odd idx); if idx parity mismatches the mode, that step SHALL move ±1 to align.
REQ-023 Steps SHALL occur every period clocks, the first occurring period clocks after acceptance; each step SHALL update coil, pulse step_pulse, and add ±1 to position (two's-complement wrap).
REQ-024 After the last step, the FSM SHALL return to IDLE and pulse done in the same cycle; cmd_steps = 0 SHALL be accepted and pulse done one cycle later with no step.
REQ-025 abort in RUN SHALL return to IDLE next cycle with a done pulse and no further step; if abort and a step are due in the same cycle, abort SHALL win; abort in IDLE SHALL be ignored.
REQ-026 coil SHALL hold its last pattern in IDLE.

Configuration
REQ-027 With STEP_MOTOR_IDLE_OFF_EN defined, coil SHALL go 0000 after IDLE_TICKS consecutive IDLE clocks (idx is kept) and SHALL re-energise on the next acceptance; without the macro, coil SHALL hold indefinitely and no timer logic SHALL exist.

Reset
REQ-028 While rst = 0, the module SHALL drive state IDLE, idx 0, coil 0000, position 0, step_pulse/done/busy 0, cmd_ready 1, and clear all counters; reset mid-move SHALL discard the move.

Structure
REQ-029 Package step_motor_pkg SHALL hold the mode encoding, state typedef and the TABLE constant.
REQ-030 Sub-module step_rate_gen SHALL be the period down-counter producing a one-cycle step tick, restarted on acceptance.

Verification
REQ-031 Half mode, forward, steps 8, period 4, idx 0: coil SHALL sequence 0011..1001, 0001 at 4-clock spacing; position +8; done once.
REQ-032 Full mode, reverse, steps 3, from idx 0: first step SHALL go to idx 7 (1001), then 5 and 3; position −3.
REQ-033 Period 0 SHALL give a step every clock; cmd_steps 0 SHALL pulse done with no step_pulse.
REQ-034 Abort asserted on the 3rd step tick of a 10-step move SHALL yield exactly 2 steps and done next cycle.
REQ-035 Changing cmd_* during RUN SHALL have no effect, and cmd_valid during RUN SHALL not be accepted.
REQ-036 With the macro defined and IDLE_TICKS set to 16: coil SHALL read 0000 after 16 idle clocks, and a new command SHALL restore TABLE[idx].
